// File: rtl/pulse_train_gen.sv
// rtl/pulse_train_gen.sv - burst generator of N rectangular pulses with programmable high/low lengths
// One accepted start latches the config and runs IDLE -> (HIGH -> LOW) x N -> IDLE with a done pulse.
module pulse_train_gen #(
  parameter int CNT_W = 16,
  parameter int NUM_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] high_len,
  input  logic [CNT_W-1:0] low_len,
  input  logic [NUM_W-1:0] num_pulses,
  output logic             wave_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [NUM_W-1:0] NUM_ONE = {{(NUM_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] phase_q, phase_d;
  logic [NUM_W-1:0] pulse_q, pulse_d;
  logic [CNT_W-1:0] hm1_q, hm1_d;
  logic [CNT_W-1:0] lm1_q, lm1_d;
  logic             wave_q, wave_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Phase lengths are stored minus one so that a zero length collapses to one cycle
  // and the all-ones length still fits without a wider counter.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    pulse_d = pulse_q;
    hm1_d   = hm1_q;
    lm1_d   = lm1_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !abort && (num_pulses != '0)) begin
          hm1_d   = (high_len == '0) ? '0 : high_len - CNT_ONE;
          lm1_d   = (low_len == '0) ? '0 : low_len - CNT_ONE;
          phase_d = hm1_d;
          pulse_d = num_pulses - NUM_ONE;
          state_d = HIGH;
        end
      end
      HIGH: begin
        if (phase_q == '0) begin
          phase_d = lm1_q;
          state_d = LOW;
        end else begin
          phase_d = phase_q - CNT_ONE;
        end
      end
      LOW: begin
        if (phase_q == '0) begin
          if (pulse_q != '0) begin
            pulse_d = pulse_q - NUM_ONE;
            phase_d = hm1_q;
            state_d = HIGH;
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end else begin
          phase_d = phase_q - CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      done_d  = 1'b0;
    end

    wave_d = (state_d == HIGH);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      phase_q <= '0;
      pulse_q <= '0;
      hm1_q   <= '0;
      lm1_q   <= '0;
      wave_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      pulse_q <= pulse_d;
      hm1_q   <= hm1_d;
      lm1_q   <= lm1_d;
      wave_q  <= wave_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign wave_out = wave_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_pulse_train_gen.sv
// tb/tb_pulse_train_gen.sv - directed table-driven bench for pulse_train_gen
// Small counter widths (4/2) so the all-ones corner is reachable in a short run.
module tb_pulse_train_gen;

  localparam int CNT_W = 4;
  localparam int NUM_W = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [CNT_W-1:0] high_len = '0;
  logic [CNT_W-1:0] low_len = '0;
  logic [NUM_W-1:0] num_pulses = '0;
  logic             wave_out, busy, done;

  int tests = 0;
  int fails = 0;

  pulse_train_gen #(.CNT_W(CNT_W), .NUM_W(NUM_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .high_len   (high_len),
    .low_len    (low_len),
    .num_pulses (num_pulses),
    .wave_out   (wave_out),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CNT_W-1:0] h;
    logic [CNT_W-1:0] l;
    logic [NUM_W-1:0] n;
    logic [31:0]      pat;
    int               len;
  } vec_t;

  vec_t vecs[5];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // pat bit (len-c) is the expected wave_out in cycle c after the start cycle.
  task automatic run_vec(input int idx);
    vec_t v;
    v = vecs[idx];
    high_len   = v.h;
    low_len    = v.l;
    num_pulses = v.n;
    start      = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= v.len; c++) begin
      check($sformatf("vec%0d cyc%0d wbd", idx, c), {29'd0, wave_out, busy, done},
            {29'd0, v.pat[v.len-c], 1'b1, 1'b0});
      step();
    end
    check($sformatf("vec%0d done", idx), {29'd0, wave_out, busy, done}, 32'b001);
    step();
    check($sformatf("vec%0d after", idx), {29'd0, wave_out, busy, done}, 32'b000);
  endtask

  initial begin
    logic saw;
    vecs[0] = '{h: 4'd3, l: 4'd2, n: 2'd2, pat: 32'b1110011100, len: 10};
    vecs[1] = '{h: 4'd0, l: 4'd0, n: 2'd3, pat: 32'b101010,     len: 6};
    vecs[2] = '{h: 4'd1, l: 4'd1, n: 2'd1, pat: 32'b10,         len: 2};
    vecs[3] = '{h: 4'd2, l: 4'd3, n: 2'd1, pat: 32'b11000,      len: 5};
    vecs[4] = '{h: 4'd1, l: 4'd2, n: 2'd2, pat: 32'b100100,     len: 6};

    step();
    step();
    check("reset outputs", {29'd0, wave_out, busy, done}, 32'b000);
    rst = 1'b0;
    step();
    check("idle after reset", {29'd0, wave_out, busy, done}, 32'b000);

    for (int i = 0; i < 5; i++) run_vec(i);

    // num_pulses = 0: start ignored
    high_len = 4'd2; low_len = 4'd2; num_pulses = 2'd0; start = 1'b1;
    step();
    start = 1'b0;
    saw = 1'b0;
    repeat (8) begin
      if (wave_out || busy || done) saw = 1'b1;
      step();
    end
    check("n0 ignored", {31'd0, saw}, 32'd0);

    // start while busy is ignored; start in the done cycle is accepted
    high_len = 4'd4; low_len = 4'd4; num_pulses = 2'd1; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      check($sformatf("busy-start cyc%0d", c), {29'd0, wave_out, busy, done},
            {29'd0, (c <= 4), (c <= 8), (c == 9)});
      if (c == 3) begin
        start = 1'b1; high_len = 4'd1;
      end else if (c == 9) begin
        start = 1'b1; high_len = 4'd2; low_len = 4'd1; num_pulses = 2'd1;
      end else begin
        start = 1'b0;
      end
      step();
    end
    start = 1'b0;
    check("b2b rise", {29'd0, wave_out, busy, done}, 32'b110);
    step();
    step();
    check("b2b low", {29'd0, wave_out, busy, done}, 32'b010);
    step();
    check("b2b done", {29'd0, wave_out, busy, done}, 32'b001);
    step();

    // abort mid-burst
    high_len = 4'd5; low_len = 4'd5; num_pulses = 2'd3; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      check($sformatf("abort cyc%0d", c), {29'd0, wave_out, busy, done},
            {29'd0, (c <= 5), 1'b1, 1'b0});
      if (c == 7) abort = 1'b1;
      step();
    end
    abort = 1'b0;
    check("abort result", {29'd0, wave_out, busy, done}, 32'b000);
    saw = 1'b0;
    repeat (40) begin
      if (done || busy) saw = 1'b1;
      step();
    end
    check("abort no done", {31'd0, saw}, 32'd0);

    // abort + start together in IDLE
    high_len = 4'd2; low_len = 4'd2; num_pulses = 2'd1; start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    saw = 1'b0;
    repeat (6) begin
      if (wave_out || busy || done) saw = 1'b1;
      step();
    end
    check("abort beats start", {31'd0, saw}, 32'd0);

    // async reset mid-HIGH, off the clock edge
    high_len = 4'd3; low_len = 4'd2; num_pulses = 2'd2; start = 1'b1;
    step();
    start = 1'b0;
    step();
    check("pre-reset high", {29'd0, wave_out, busy, done}, 32'b110);
    #2;
    rst = 1'b1;
    #1;
    check("async reset", {29'd0, wave_out, busy, done}, 32'b000);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    check("post reset idle", {29'd0, wave_out, busy, done}, 32'b000);
    run_vec(0);

    // all-ones lengths and count
    high_len = 4'd15; low_len = 4'd15; num_pulses = 2'd3; start = 1'b1;
    step();
    start = 1'b0;
    saw = 1'b0;
    for (int c = 1; c <= 90; c++) begin
      if ((wave_out !== (((c - 1) % 30) < 15)) || (busy !== 1'b1) || (done !== 1'b0)) saw = 1'b1;
      step();
    end
    check("max burst shape", {31'd0, saw}, 32'd0);
    check("max done c91", {29'd0, wave_out, busy, done}, 32'b001);
    step();
    check("max after", {29'd0, wave_out, busy, done}, 32'b000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
